// File: rtl/coproc_pkg.sv
// Shared definitions for the coprocessor eXtension-interface blocks:
// exception codes, memory access size encoding and responder FSM states.
package coproc_pkg;

    localparam logic [5:0] EXC_LD_MISALIGN = 6'd4;
    localparam logic [5:0] EXC_LD_FAULT    = 6'd5;
    localparam logic [5:0] EXC_ST_MISALIGN = 6'd6;
    localparam logic [5:0] EXC_ST_FAULT    = 6'd7;

    typedef enum logic [2:0] {
        MEM_SIZE_BYTE = 3'd0,
        MEM_SIZE_HALF = 3'd1,
        MEM_SIZE_WORD = 3'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS_REQ,
        ST_BUS_WAIT,
        ST_RESULT
    } resp_state_e;

endpackage

// File: rtl/xif_mem_checker.sv
// Combinational alignment and address-window check for one memory request.
// Misalignment takes priority over an access fault.
module xif_mem_checker
    import coproc_pkg::*;
#(
    parameter logic [31:0] PMA_BASE = 32'h0000_0000,
    parameter logic [31:0] PMA_SIZE = 32'h0001_0000
) (
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic        we,
    output logic        exc,
    output logic [5:0]  exccode
);

    logic        misaligned;
    logic        fault;
    logic [32:0] addr_ext;
    logic [32:0] win_lo;
    logic [32:0] win_hi;

    // 33-bit bounds so a window ending at 4 GiB does not wrap to zero
    assign addr_ext = {1'b0, addr};
    assign win_lo   = {1'b0, PMA_BASE};
    assign win_hi   = {1'b0, PMA_BASE} + {1'b0, PMA_SIZE};

    always_comb begin
        misaligned = 1'b0;
        case (size)
            MEM_SIZE_BYTE: misaligned = 1'b0;
            MEM_SIZE_HALF: misaligned = addr[0];
            MEM_SIZE_WORD: misaligned = |addr[1:0];
            default:       misaligned = 1'b1;
        endcase

        fault   = (addr_ext < win_lo) || (addr_ext >= win_hi);
        exc     = misaligned || fault;
        exccode = '0;
        if (misaligned) begin
            exccode = we ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
        end else if (fault) begin
            exccode = we ? EXC_ST_FAULT : EXC_LD_FAULT;
        end
    end

endmodule

// File: rtl/xif_mem_responder.sv
// Core-side responder for the eXtension-interface memory channel: checks one
// request at a time and issues legal ones as a single OBI data-bus transaction.
module xif_mem_responder
    import coproc_pkg::*;
#(
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned X_MEM_WIDTH = 32,
    parameter logic [31:0] PMA_BASE    = 32'h0000_0000,
    parameter logic [31:0] PMA_SIZE    = 32'h0001_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic                     mem_valid_i,
    output logic                     mem_ready_o,
    input  logic [X_ID_WIDTH-1:0]    mem_id_i,
    input  logic [31:0]              mem_addr_i,
    input  logic                     mem_we_i,
    input  logic [2:0]               mem_size_i,
    input  logic [X_MEM_WIDTH/8-1:0] mem_be_i,
    input  logic [X_MEM_WIDTH-1:0]   mem_wdata_i,
    output logic                     mem_exc_o,
    output logic [5:0]               mem_exccode_o,

    output logic                     mem_result_valid_o,
    output logic [X_ID_WIDTH-1:0]    mem_result_id_o,
    output logic [X_MEM_WIDTH-1:0]   mem_result_rdata_o,
    output logic                     mem_result_err_o,

    output logic                     obi_req_o,
    input  logic                     obi_gnt_i,
    output logic [31:0]              obi_addr_o,
    output logic                     obi_we_o,
    output logic [X_MEM_WIDTH/8-1:0] obi_be_o,
    output logic [X_MEM_WIDTH-1:0]   obi_wdata_o,
    input  logic                     obi_rvalid_i,
    input  logic [X_MEM_WIDTH-1:0]   obi_rdata_i,
    input  logic                     obi_err_i
);

    resp_state_e state_q;
    resp_state_e state_d;

    logic       chk_exc;
    logic [5:0] chk_exccode;
    logic       launch;
    logic       capture;

    logic [X_ID_WIDTH-1:0]    id_q;
    logic [31:2]              addr_q;
    logic                     we_q;
    logic [X_MEM_WIDTH/8-1:0] be_q;
    logic [X_MEM_WIDTH-1:0]   wdata_q;

    logic [X_ID_WIDTH-1:0]    res_id_q;
    logic [X_MEM_WIDTH-1:0]   res_rdata_q;
    logic                     res_err_q;

    xif_mem_checker #(
        .PMA_BASE (PMA_BASE),
        .PMA_SIZE (PMA_SIZE)
    ) u_checker (
        .addr    (mem_addr_i),
        .size    (mem_size_i),
        .we      (mem_we_i),
        .exc     (chk_exc),
        .exccode (chk_exccode)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        mem_ready_o        = 1'b0;
        mem_exc_o          = 1'b0;
        mem_exccode_o      = '0;
        obi_req_o          = 1'b0;
        mem_result_valid_o = 1'b0;
        launch             = 1'b0;
        capture            = 1'b0;

        case (state_q)
            ST_IDLE: begin
                mem_ready_o = 1'b1;
                // Faulting requests are consumed here and never reach the bus
                if (mem_valid_i) begin
                    if (chk_exc) begin
                        mem_exc_o     = 1'b1;
                        mem_exccode_o = chk_exccode;
                    end else begin
                        launch  = 1'b1;
                        state_d = ST_BUS_REQ;
                    end
                end
            end
            ST_BUS_REQ: begin
                obi_req_o = 1'b1;
                if (obi_gnt_i) begin
                    state_d = ST_BUS_WAIT;
                end
            end
            ST_BUS_WAIT: begin
                if (obi_rvalid_i) begin
                    capture = 1'b1;
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                mem_result_valid_o = 1'b1;
                state_d            = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result fields live in their own registers so they hold between pulses
    // even while the next request is being latched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q        <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            res_id_q    <= '0;
            res_rdata_q <= '0;
            res_err_q   <= 1'b0;
        end else begin
            if (launch) begin
                id_q    <= mem_id_i;
                addr_q  <= mem_addr_i[31:2];
                we_q    <= mem_we_i;
                be_q    <= mem_be_i;
                wdata_q <= mem_wdata_i;
            end
            if (capture) begin
                res_id_q    <= id_q;
                res_rdata_q <= we_q ? '0 : obi_rdata_i;
                res_err_q   <= obi_err_i;
            end
        end
    end

    assign obi_addr_o         = {addr_q, 2'b00};
    assign obi_we_o           = we_q;
    assign obi_be_o           = be_q;
    assign obi_wdata_o        = wdata_q;
    assign mem_result_id_o    = res_id_q;
    assign mem_result_rdata_o = res_rdata_q;
    assign mem_result_err_o   = res_err_q;

endmodule

// File: tb/tb_xif_mem_responder.sv
// Directed self-checking bench for xif_mem_responder.
module tb_xif_mem_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic [3:0]  mem_id_i;
    logic [31:0] mem_addr_i;
    logic        mem_we_i;
    logic [2:0]  mem_size_i;
    logic [3:0]  mem_be_i;
    logic [31:0] mem_wdata_i;
    logic        mem_exc_o;
    logic [5:0]  mem_exccode_o;
    logic        mem_result_valid_o;
    logic [3:0]  mem_result_id_o;
    logic [31:0] mem_result_rdata_o;
    logic        mem_result_err_o;
    logic        obi_req_o;
    logic        obi_gnt_i;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i;
    logic [31:0] obi_rdata_i;
    logic        obi_err_i;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int p0;

    xif_mem_responder #(
        .X_ID_WIDTH  (4),
        .X_MEM_WIDTH (32),
        .PMA_BASE    (32'h0000_0000),
        .PMA_SIZE    (32'h0001_0000)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .mem_valid_i        (mem_valid_i),
        .mem_ready_o        (mem_ready_o),
        .mem_id_i           (mem_id_i),
        .mem_addr_i         (mem_addr_i),
        .mem_we_i           (mem_we_i),
        .mem_size_i         (mem_size_i),
        .mem_be_i           (mem_be_i),
        .mem_wdata_i        (mem_wdata_i),
        .mem_exc_o          (mem_exc_o),
        .mem_exccode_o      (mem_exccode_o),
        .mem_result_valid_o (mem_result_valid_o),
        .mem_result_id_o    (mem_result_id_o),
        .mem_result_rdata_o (mem_result_rdata_o),
        .mem_result_err_o   (mem_result_err_o),
        .obi_req_o          (obi_req_o),
        .obi_gnt_i          (obi_gnt_i),
        .obi_addr_o         (obi_addr_o),
        .obi_we_o           (obi_we_o),
        .obi_be_o           (obi_be_o),
        .obi_wdata_o        (obi_wdata_o),
        .obi_rvalid_i       (obi_rvalid_i),
        .obi_rdata_i        (obi_rdata_i),
        .obi_err_i          (obi_err_i)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (mem_result_valid_o) pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic drive_req(input logic [3:0] id, input logic [31:0] addr, input logic we,
                             input logic [2:0] size, input logic [3:0] be, input logic [31:0] wdata);
        mem_valid_i = 1'b1;
        mem_id_i    = id;
        mem_addr_i  = addr;
        mem_we_i    = we;
        mem_size_i  = size;
        mem_be_i    = be;
        mem_wdata_i = wdata;
    endtask

    task automatic idle_req();
        mem_valid_i = 1'b0;
        mem_id_i    = '0;
        mem_addr_i  = '0;
        mem_we_i    = 1'b0;
        mem_size_i  = '0;
        mem_be_i    = '0;
        mem_wdata_i = '0;
    endtask

    // Exception vectors: {addr, size, we, expected exccode}
    logic [31:0] exc_addr [6] = '{32'h0000_0101, 32'h0001_0000, 32'h0001_0000,
                                   32'h0000_0102, 32'h0001_0001, 32'h0000_0100};
    logic [2:0]  exc_size [6] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd1, 3'd3};
    logic        exc_we   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [5:0]  exc_code [6] = '{6'd4, 6'd7, 6'd5, 6'd6, 6'd6, 6'd4};

    initial begin
        idle_req();
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b0;
        obi_rdata_i  = '0;
        obi_err_i    = 1'b0;
        rst_i        = 1'b1;
        repeat (3) cyc();
        rst_i = 1'b0;
        settle();
        check_eq("rst_ready", mem_ready_o, 1);
        check_eq("rst_exc", mem_exc_o, 0);
        check_eq("rst_req", obi_req_o, 0);
        check_eq("rst_res_valid", mem_result_valid_o, 0);
        check_eq("rst_addr", obi_addr_o, 0);

        // Word store to 0x100, immediate grant, rvalid one cycle later
        cyc();
        drive_req(4'h1, 32'h100, 1'b1, 3'd2, 4'hF, 32'hCAFE_F00D);
        settle();
        check_eq("st_accept_exc", mem_exc_o, 0);
        cyc();
        idle_req();
        obi_gnt_i = 1'b1;
        settle();
        check_eq("st_req", obi_req_o, 1);
        check_eq("st_addr", obi_addr_o, 32'h100);
        check_eq("st_we", obi_we_o, 1);
        check_eq("st_be", obi_be_o, 4'hF);
        check_eq("st_wdata", obi_wdata_o, 32'hCAFE_F00D);
        cyc();
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = 32'hDEAD_BEEF;
        settle();
        check_eq("st_wait_no_pulse", mem_result_valid_o, 0);
        check_eq("st_wait_req", obi_req_o, 0);
        cyc();
        obi_rvalid_i = 1'b0;
        settle();
        check_eq("st_res_valid", mem_result_valid_o, 1);
        check_eq("st_res_id", mem_result_id_o, 4'h1);
        check_eq("st_res_rdata", mem_result_rdata_o, 0);
        check_eq("st_res_err", mem_result_err_o, 0);
        cyc();
        settle();
        check_eq("st_pulse_end", mem_result_valid_o, 0);
        check_eq("st_ready_again", mem_ready_o, 1);
        check_eq("st_res_id_hold", mem_result_id_o, 4'h1);

        // Word load from 0x204, grant delayed 3 cycles
        cyc();
        drive_req(4'h5, 32'h204, 1'b0, 3'd2, 4'hF, 32'h0);
        settle();
        check_eq("ld_accept_exc", mem_exc_o, 0);
        cyc();
        idle_req();
        for (int i = 0; i < 4; i++) begin
            obi_gnt_i = (i == 3);
            settle();
            check_eq("ld_req_held", obi_req_o, 1);
            check_eq("ld_addr_stable", obi_addr_o, 32'h204);
            check_eq("ld_we", obi_we_o, 0);
            cyc();
        end
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = 32'h1234_5678;
        settle();
        check_eq("ld_wait_req", obi_req_o, 0);
        cyc();
        obi_rvalid_i = 1'b0;
        settle();
        check_eq("ld_res_valid", mem_result_valid_o, 1);
        check_eq("ld_res_id", mem_result_id_o, 4'h5);
        check_eq("ld_res_rdata", mem_result_rdata_o, 32'h1234_5678);
        check_eq("ld_res_err", mem_result_err_o, 0);
        cyc();

        // Exception vectors: no bus request, no result
        p0 = pulses;
        for (int i = 0; i < 6; i++) begin
            drive_req(4'h6, exc_addr[i], exc_we[i], exc_size[i], 4'hF, 32'h0);
            settle();
            check_eq("exc_flag", mem_exc_o, 1);
            check_eq("exc_code", mem_exccode_o, exc_code[i]);
            check_eq("exc_ready", mem_ready_o, 1);
            check_eq("exc_no_req", obi_req_o, 0);
            cyc();
        end
        idle_req();
        settle();
        check_eq("exc_after_req", obi_req_o, 0);
        check_eq("exc_after_clear", mem_exc_o, 0);
        cyc();
        cyc();
        check_eq("exc_no_result", pulses, p0);

        // Last legal word of the window, grant in the first request cycle
        drive_req(4'h7, 32'h0000_FFFC, 1'b1, 3'd2, 4'hC, 32'h55AA_55AA);
        settle();
        check_eq("edge_exc", mem_exc_o, 0);
        cyc();
        idle_req();
        obi_gnt_i = 1'b1;
        settle();
        check_eq("edge_req", obi_req_o, 1);
        check_eq("edge_addr", obi_addr_o, 32'h0000_FFFC);
        check_eq("edge_be", obi_be_o, 4'hC);
        cyc();
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = 32'h7777_7777;
        cyc();
        obi_rvalid_i = 1'b0;
        settle();
        check_eq("edge_res_valid", mem_result_valid_o, 1);
        check_eq("edge_res_id", mem_result_id_o, 4'h7);
        check_eq("edge_res_rdata", mem_result_rdata_o, 0);
        cyc();

        // Load terminating with a bus error
        drive_req(4'h8, 32'h40, 1'b0, 3'd2, 4'hF, 32'h0);
        cyc();
        idle_req();
        obi_gnt_i = 1'b1;
        cyc();
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b1;
        obi_err_i    = 1'b1;
        obi_rdata_i  = 32'h0BAD_F00D;
        cyc();
        obi_rvalid_i = 1'b0;
        obi_err_i    = 1'b0;
        settle();
        check_eq("err_res_valid", mem_result_valid_o, 1);
        check_eq("err_res_err", mem_result_err_o, 1);
        check_eq("err_res_rdata", mem_result_rdata_o, 32'h0BAD_F00D);
        check_eq("err_res_id", mem_result_id_o, 4'h8);
        cyc();
        settle();
        check_eq("err_hold", mem_result_err_o, 1);

        // Second request held while the first is outstanding
        cyc();
        drive_req(4'h2, 32'h300, 1'b0, 3'd2, 4'hF, 32'h0);
        cyc();
        idle_req();
        obi_gnt_i = 1'b1;
        settle();
        check_eq("b2b_req1", obi_req_o, 1);
        cyc();
        obi_gnt_i = 1'b0;
        drive_req(4'h3, 32'h304, 1'b1, 3'd2, 4'hF, 32'hA5A5_A5A5);
        settle();
        check_eq("b2b_ready_wait", mem_ready_o, 0);
        check_eq("b2b_exc_wait", mem_exc_o, 0);
        cyc();
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = 32'h1111_2222;
        settle();
        check_eq("b2b_ready_wait2", mem_ready_o, 0);
        cyc();
        obi_rvalid_i = 1'b0;
        settle();
        check_eq("b2b_res1_valid", mem_result_valid_o, 1);
        check_eq("b2b_res1_id", mem_result_id_o, 4'h2);
        check_eq("b2b_res1_rdata", mem_result_rdata_o, 32'h1111_2222);
        check_eq("b2b_ready_result", mem_ready_o, 0);
        cyc();
        settle();
        check_eq("b2b_ready_accept", mem_ready_o, 1);
        check_eq("b2b_no_pulse", mem_result_valid_o, 0);
        cyc();
        idle_req();
        obi_gnt_i = 1'b1;
        settle();
        check_eq("b2b_req2", obi_req_o, 1);
        check_eq("b2b_addr2", obi_addr_o, 32'h304);
        check_eq("b2b_we2", obi_we_o, 1);
        check_eq("b2b_wdata2", obi_wdata_o, 32'hA5A5_A5A5);
        check_eq("b2b_res_id_hold", mem_result_id_o, 4'h2);
        cyc();
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = 32'h3333_4444;
        cyc();
        obi_rvalid_i = 1'b0;
        settle();
        check_eq("b2b_res2_valid", mem_result_valid_o, 1);
        check_eq("b2b_res2_id", mem_result_id_o, 4'h3);
        check_eq("b2b_res2_rdata", mem_result_rdata_o, 0);
        cyc();

        // Reset in BUS_WAIT followed by a stray rvalid
        drive_req(4'h9, 32'h500, 1'b0, 3'd2, 4'hF, 32'h0);
        cyc();
        idle_req();
        obi_gnt_i = 1'b1;
        cyc();
        obi_gnt_i = 1'b0;
        rst_i     = 1'b1;
        cyc();
        rst_i = 1'b0;
        p0    = pulses;
        settle();
        check_eq("mid_rst_req", obi_req_o, 0);
        check_eq("mid_rst_ready", mem_ready_o, 1);
        check_eq("mid_rst_res_valid", mem_result_valid_o, 0);
        check_eq("mid_rst_addr", obi_addr_o, 0);
        check_eq("mid_rst_be", obi_be_o, 0);
        check_eq("mid_rst_res_id", mem_result_id_o, 0);
        check_eq("mid_rst_res_rdata", mem_result_rdata_o, 0);
        check_eq("mid_rst_res_err", mem_result_err_o, 0);
        cyc();
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = 32'h9999_9999;
        cyc();
        obi_rvalid_i = 1'b0;
        settle();
        check_eq("stray_no_pulse", mem_result_valid_o, 0);
        check_eq("stray_rdata", mem_result_rdata_o, 0);
        check_eq("stray_ready", mem_ready_o, 1);
        cyc();
        cyc();
        check_eq("stray_pulse_count", pulses, p0);
        check_eq("total_pulses", pulses, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xif_mem_responder.md
# xif_mem_responder

Core-side responder for the eXtension-interface memory channel. It accepts one coprocessor memory request at a time on the mem/mem_result handshake and checks alignment and the address window. Legal requests go out as a single OBI data-bus transaction, and the read data or bus error comes back on mem_result. It sits between the coprocessor's mem port and the data-memory OBI bus.

## Interface
Parameters:
- X_ID_WIDTH, 4, instruction ID width
- X_MEM_WIDTH, 32, data width (only 32 supported)
- PMA_BASE, 32'h0000_0000, first legal byte address
- PMA_SIZE, 32'h0001_0000, legal window size in bytes

Ports:
- clk_i  in  1  clock; one clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- mem_valid_i  in  1  request valid
- mem_ready_o  out  1  request accepted when high with mem_valid_i
- mem_id_i  in  X_ID_WIDTH  instruction ID
- mem_addr_i  in  32  byte address
- mem_we_i  in  1  1 = store
- mem_size_i  in  3  0 byte, 1 half, 2 word, others illegal
- mem_be_i  in  4  byte enables
- mem_wdata_i  in  32  store data
- mem_exc_o  out  1  exception response, valid in the accept cycle
- mem_exccode_o  out  6  exception code, valid with mem_exc_o
- mem_result_valid_o  out  1  one-cycle result pulse
- mem_result_id_o  out  X_ID_WIDTH  ID of the completed request
- mem_result_rdata_o  out  32  raw bus word; 0 for stores
- mem_result_err_o  out  1  bus error
- obi_req_o  out  1  bus request
- obi_gnt_i  in  1  bus grant
- obi_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- obi_we_o  out  1  write enable
- obi_be_o  out  4  byte enables
- obi_wdata_o  out  32  write data
- obi_rvalid_i  in  1  response valid
- obi_rdata_i  in  32  read data
- obi_err_i  in  1  bus error

## Operation
The FSM has four states: IDLE, BUS_REQ, BUS_WAIT, RESULT.

IDLE:
- mem_ready_o = 1.
- Acceptance is mem_valid_i && mem_ready_o.
- On acceptance, the checker result is presented combinationally the same cycle on mem_exc_o/mem_exccode_o.

Exception checks:
- Misaligned: size 1 with addr[0]≠0, size 2 with addr[1:0]≠0, or size>2 → exccode 4 (load) / 6 (store).
- Access fault: addr < PMA_BASE or addr ≥ PMA_BASE+PMA_SIZE, computed with 33-bit arithmetic so there is no wrap → exccode 5 (load) / 7 (store).
- Misaligned has priority over access fault.
- On an exception there is no bus transaction and no mem_result, and the FSM stays in IDLE.

Legal request:
- Latch id, addr, we, be, wdata; go to BUS_REQ.

BUS_REQ:
- obi_req_o = 1 with stable address and control until obi_gnt_i, then go to BUS_WAIT.

BUS_WAIT:
- On obi_rvalid_i, latch rdata (stores: 0) and err, then go to RESULT.

RESULT:
- mem_result_valid_o = 1 for exactly one cycle, then IDLE.

Other rules:
- mem_ready_o = 0 in every non-IDLE state, so only one request is outstanding.
- obi_rvalid_i outside BUS_WAIT is ignored.
- mem_result_* fields hold their values between pulses.

## Timing
- Reset values: mem_ready_o 1, all other outputs 0, state IDLE.
- Accept at cycle N → obi_req_o high from N+1.
- Grant at cycle G (G ≥ N+1) → BUS_WAIT from G+1.
- rvalid at R (R ≥ G+1) → mem_result_valid_o at R+1.
- Minimum latency from accept to result is 3 cycles.
- Back-to-back: the next request can be accepted at the cycle after the result pulse at the earliest.
- A grant in the same cycle obi_req_o first rises is legal.
- rst_i mid-transaction: next cycle IDLE, obi_req_o 0, no result pulse. A late rvalid is ignored.

## Structure
- Shared in coproc_pkg:
  - exccode constants (EXC_LD_MISALIGN=4, EXC_LD_FAULT=5, EXC_ST_MISALIGN=6, EXC_ST_FAULT=7)
  - the mem_size encoding
  - the responder state enum
- Sub-module xif_mem_checker: purely combinational alignment/PMA check (addr, size, we → exc, exccode).

## Test plan
- Word store to 0x100, be=4'hF, wdata=0xCAFEF00D, immediate gnt and rvalid one cycle later:
  - obi_addr_o=0x100, obi_we_o=1.
  - mem_result_valid_o pulses 3 cycles after accept with err=0, rdata=0.
- Word load from 0x204, gnt delayed 3 cycles, rdata=0x12345678:
  - obi_req_o held stable for 4 cycles.
  - Result id equals the issued id, rdata=0x12345678.
- Halfword load at 0x101 → mem_exc_o=1, mem_exccode_o=4 in the accept cycle; no obi_req_o, no result.
- Word store at PMA_BASE+PMA_SIZE → exccode 7. Word store at PMA_BASE+PMA_SIZE−4 → legal transaction.
- Load with obi_err_i=1 on rvalid → result pulse with err=1.
- Second mem_valid_i held during BUS_WAIT → mem_ready_o stays 0 until after the first result pulse, then it is accepted.
- rst_i asserted during BUS_WAIT, then stray rvalid → all outputs at reset values, no result pulse.
